alu_issue_stage: RTL and testbench

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

---
 rtl/alu16_defs_pkg.sv | 32 +++
 rtl/alu_issue_stage_if.sv | 39 +++
 rtl/alu_ctrl_decode.sv | 26 ++
 rtl/alu_issue_stage.sv | 116 +++++++++++
 tb/tb_alu_issue_stage.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu16_defs_pkg.sv
// Shared ALU16 definitions: opcode constants, ALU op encodings and the decoded control word.
package alu16_defs;

   localparam int unsigned OPCODE_W = 4;
   localparam int unsigned OP_W     = 2;
   localparam int unsigned CNT_W    = 8;

   localparam logic [OPCODE_W-1:0] OPC_ADD  = 4'h0;
   localparam logic [OPCODE_W-1:0] OPC_SUB  = 4'h1;
   localparam logic [OPCODE_W-1:0] OPC_AND  = 4'h2;
   localparam logic [OPCODE_W-1:0] OPC_OR   = 4'h3;
   localparam logic [OPCODE_W-1:0] OPC_NOR  = 4'h4;
   localparam logic [OPCODE_W-1:0] OPC_SLT  = 4'h5;
   localparam logic [OPCODE_W-1:0] OPC_ADDI = 4'h6;
   localparam logic [OPCODE_W-1:0] OPC_SLTI = 4'h7;

   typedef enum logic [OP_W-1:0] {
      OP_AND = 2'b00,
      OP_OR  = 2'b01,
      OP_ADD = 2'b10,
      OP_SLT = 2'b11
   } alu_op_e;

   typedef struct packed {
      logic    a_invert;
      logic    b_negate;
      alu_op_e op;
      logic    use_imm;
      logic    illegal;
   } alu_ctrl_t;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Upstream issue and downstream ALU operand handshake bundle for the issue stage.
interface alu_issue_stage_if #(
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned RADDR_W = 3,
   parameter int unsigned IMM_W   = 8
);
   import alu16_defs::*;

   logic                InValid;
   logic                InReady;
   logic [OPCODE_W-1:0] Opcode;
   logic [DATA_W-1:0]   RsData;
   logic [DATA_W-1:0]   RtData;
   logic [IMM_W-1:0]    Imm;
   logic [RADDR_W-1:0]  RdAddr;

   logic                OutValid;
   logic                OutReady;
   logic [DATA_W-1:0]   A;
   logic [DATA_W-1:0]   B;
   logic                AInvert;
   logic                BNegate;
   logic [OP_W-1:0]     Op;
   logic [RADDR_W-1:0]  RdAddrOut;
   logic [CNT_W-1:0]    IllegalCount;

   // Issuer / consumer side
   modport master (
      output InValid, Opcode, RsData, RtData, Imm, RdAddr, OutReady,
      input  InReady, OutValid, A, B, AInvert, BNegate, Op, RdAddrOut, IllegalCount
   );

   // Issue stage side
   modport slave (
      input  InValid, Opcode, RsData, RtData, Imm, RdAddr, OutReady,
      output InReady, OutValid, A, B, AInvert, BNegate, Op, RdAddrOut, IllegalCount
   );

endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational opcode decoder producing ALU16 control bits and operand selection.
module alu_ctrl_decode
   import alu16_defs::*;
(
   input  logic [OPCODE_W-1:0] opcode,
   output alu_ctrl_t           ctrl_c
);

   always_comb begin
      ctrl_c          = '0;
      ctrl_c.op       = OP_ADD;
      ctrl_c.illegal  = 1'b0;
      unique case (opcode)
         OPC_ADD:  ctrl_c.op = OP_ADD;
         OPC_SUB:  begin ctrl_c.b_negate = 1'b1; ctrl_c.op = OP_ADD; end
         OPC_AND:  ctrl_c.op = OP_AND;
         OPC_OR:   ctrl_c.op = OP_OR;
         OPC_NOR:  begin ctrl_c.a_invert = 1'b1; ctrl_c.b_negate = 1'b1; ctrl_c.op = OP_AND; end
         OPC_SLT:  begin ctrl_c.b_negate = 1'b1; ctrl_c.op = OP_SLT; end
         OPC_ADDI: begin ctrl_c.use_imm = 1'b1; ctrl_c.op = OP_ADD; end
         OPC_SLTI: begin ctrl_c.use_imm = 1'b1; ctrl_c.b_negate = 1'b1; ctrl_c.op = OP_SLT; end
         default:  ctrl_c.illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes instructions and holds them in a 2-entry skid buffer
// (output register + skid register) ahead of the ALU16 datapath.
module alu_issue_stage
   import alu16_defs::*;
#(
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned RADDR_W = 3,
   parameter int unsigned IMM_W   = 8
) (
   input  logic             Clock,
   input  logic             Reset,
   alu_issue_stage_if.slave bus
);

   typedef struct packed {
      logic [DATA_W-1:0]  a;
      logic [DATA_W-1:0]  b;
      logic               a_invert;
      logic               b_negate;
      logic [OP_W-1:0]    op;
      logic [RADDR_W-1:0] rd;
   } entry_t;

   alu_ctrl_t        dec_c;
   entry_t           in_entry_c;
   logic             accept_c, push_c, pop_c;

   entry_t           out_q, out_d;
   entry_t           skid_q, skid_d;
   logic             out_valid_q, out_valid_d;
   logic             skid_valid_q, skid_valid_d;
   logic             in_ready_q, in_ready_d;
   logic [CNT_W-1:0] ill_cnt_q, ill_cnt_d;

   alu_ctrl_decode u_decode (
      .opcode (bus.Opcode),
      .ctrl_c (dec_c)
   );

   // Operand/control payload for the instruction currently offered upstream
   always_comb begin
      in_entry_c          = '0;
      in_entry_c.a        = bus.RsData;
      in_entry_c.b        = dec_c.use_imm ? DATA_W'($signed(bus.Imm)) : bus.RtData;
      in_entry_c.a_invert = dec_c.a_invert;
      in_entry_c.b_negate = dec_c.b_negate;
      in_entry_c.op       = OP_W'(dec_c.op);
      in_entry_c.rd       = bus.RdAddr;
   end

   assign accept_c = bus.InValid & in_ready_q;
   assign push_c   = accept_c & ~dec_c.illegal;
   assign pop_c    = out_valid_q & bus.OutReady;

   // Skid buffer steering; illegal opcodes are consumed without taking an entry
   always_comb begin
      out_d        = out_q;
      skid_d       = skid_q;
      out_valid_d  = out_valid_q;
      skid_valid_d = skid_valid_q;
      ill_cnt_d    = ill_cnt_q;

      if (!out_valid_q || pop_c) begin
         if (skid_valid_q) begin
            out_d        = skid_q;
            out_valid_d  = 1'b1;
            skid_d       = '0;
            skid_valid_d = 1'b0;
         end else if (push_c) begin
            out_d       = in_entry_c;
            out_valid_d = 1'b1;
         end else begin
            out_d       = '0;
            out_valid_d = 1'b0;
         end
      end else if (push_c) begin
         skid_d       = in_entry_c;
         skid_valid_d = 1'b1;
      end

      in_ready_d = ~skid_valid_d;

      if (accept_c && dec_c.illegal && (ill_cnt_q != {CNT_W{1'b1}})) begin
         ill_cnt_d = ill_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         out_q        <= '0;
         skid_q       <= '0;
         out_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
         in_ready_q   <= 1'b0;
         ill_cnt_q    <= '0;
      end else begin
         out_q        <= out_d;
         skid_q       <= skid_d;
         out_valid_q  <= out_valid_d;
         skid_valid_q <= skid_valid_d;
         in_ready_q   <= in_ready_d;
         ill_cnt_q    <= ill_cnt_d;
      end
   end

   assign bus.InReady      = in_ready_q;
   assign bus.OutValid     = out_valid_q;
   assign bus.A            = out_q.a;
   assign bus.B            = out_q.b;
   assign bus.AInvert      = out_q.a_invert;
   assign bus.BNegate      = out_q.b_negate;
   assign bus.Op           = out_q.op;
   assign bus.RdAddrOut    = out_q.rd;
   assign bus.IllegalCount = ill_cnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed scenarios plus a randomized
// stream scored against a queue-based reference model.
module tb_alu_issue_stage;

   localparam int unsigned DATA_W  = 16;
   localparam int unsigned RADDR_W = 3;
   localparam int unsigned IMM_W   = 8;
   localparam int unsigned ENT_W   = 2*DATA_W + 4 + RADDR_W;

   logic Clock;
   logic Reset;
   int   n_cmp;
   int   n_err;

   alu_issue_stage_if #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .IMM_W(IMM_W)) bus ();

   alu_issue_stage #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .IMM_W(IMM_W)) dut (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (bus)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic drive(input logic v, input logic [3:0] opc, input logic [15:0] rs,
                        input logic [15:0] rt, input logic [7:0] imm, input logic [2:0] rd);
      bus.InValid = v;
      bus.Opcode  = opc;
      bus.RsData  = rs;
      bus.RtData  = rt;
      bus.Imm     = imm;
      bus.RdAddr  = rd;
   endtask

   // Expected {AInvert, BNegate, Op} straight from the opcode table
   function automatic logic [3:0] ref_ctrl(input logic [3:0] opc);
      case (opc)
         4'h0: return 4'b0010;
         4'h1: return 4'b0110;
         4'h2: return 4'b0000;
         4'h3: return 4'b0001;
         4'h4: return 4'b1100;
         4'h5: return 4'b0111;
         4'h6: return 4'b0010;
         4'h7: return 4'b0111;
         default: return 4'b0000;
      endcase
   endfunction

   function automatic logic [ENT_W-1:0] ref_entry(input logic [3:0] opc, input logic [15:0] rs,
                                                  input logic [15:0] rt, input logic [7:0] imm,
                                                  input logic [2:0] rd);
      logic [15:0] b;
      b = (opc >= 4'h6) ? {{8{imm[7]}}, imm} : rt;
      return {rs, b, ref_ctrl(opc), rd};
   endfunction

   function automatic logic [ENT_W-1:0] snap();
      return {bus.A, bus.B, bus.AInvert, bus.BNegate, bus.Op, bus.RdAddrOut};
   endfunction

   task automatic test_reset();
      Reset = 1'b1;
      tick();
      tick();
      n_cmp++; if (bus.OutValid !== 1'b0) begin n_err++; $display("FAIL reset_outvalid got %b want 0", bus.OutValid); end
      n_cmp++; if (bus.IllegalCount !== 8'h00) begin n_err++; $display("FAIL reset_count got %h want 00", bus.IllegalCount); end
      n_cmp++; if (bus.InReady !== 1'b0) begin n_err++; $display("FAIL reset_inready got %b want 0", bus.InReady); end
      n_cmp++; if (snap() !== '0) begin n_err++; $display("FAIL reset_outputs got %h want 0", snap()); end
      Reset = 1'b0;
      tick();
      n_cmp++; if (bus.InReady !== 1'b1) begin n_err++; $display("FAIL reset_release_inready got %b want 1", bus.InReady); end
   endtask

   task automatic test_sub();
      bus.OutReady = 1'b1;
      drive(1'b1, 4'h1, 16'h0005, 16'h0003, 8'h00, 3'd1);
      tick();
      drive(1'b0, 4'h0, 16'h0, 16'h0, 8'h0, 3'd0);
      n_cmp++; if (bus.OutValid !== 1'b1) begin n_err++; $display("FAIL sub_valid got %b want 1", bus.OutValid); end
      n_cmp++; if ({bus.A, bus.B} !== {16'h0005, 16'h0003}) begin n_err++; $display("FAIL sub_operands got %h/%h want 0005/0003", bus.A, bus.B); end
      n_cmp++; if ({bus.AInvert, bus.BNegate, bus.Op} !== 4'b0110) begin n_err++; $display("FAIL sub_ctrl got %b want 0110", {bus.AInvert, bus.BNegate, bus.Op}); end
      tick();
      n_cmp++; if ({bus.OutValid, snap()} !== '0) begin n_err++; $display("FAIL sub_drained got %b/%h want 0/0", bus.OutValid, snap()); end
   endtask

   task automatic test_imm();
      bus.OutReady = 1'b1;
      drive(1'b1, 4'h6, 16'h1000, 16'h5555, 8'hFE, 3'd2);
      tick();
      drive(1'b1, 4'h7, 16'h0042, 16'h5555, 8'h7F, 3'd3);
      n_cmp++; if ({bus.A, bus.B} !== {16'h1000, 16'hFFFE}) begin n_err++; $display("FAIL addi_operands got %h/%h want 1000/fffe", bus.A, bus.B); end
      n_cmp++; if ({bus.BNegate, bus.Op} !== 3'b010) begin n_err++; $display("FAIL addi_ctrl got %b want 010", {bus.BNegate, bus.Op}); end
      tick();
      drive(1'b0, 4'h0, 16'h0, 16'h0, 8'h0, 3'd0);
      n_cmp++; if ({bus.OutValid, bus.B, bus.RdAddrOut} !== {1'b1, 16'h007F, 3'd3}) begin n_err++; $display("FAIL slti_operand got %b/%h/%0d want 1/007f/3", bus.OutValid, bus.B, bus.RdAddrOut); end
      n_cmp++; if ({bus.BNegate, bus.Op} !== 3'b111) begin n_err++; $display("FAIL slti_ctrl got %b want 111", {bus.BNegate, bus.Op}); end
      tick();
   endtask

   task automatic test_skid();
      bus.OutReady = 1'b0;
      drive(1'b1, 4'h0, 16'h0100, 16'h0001, 8'h0, 3'd1);
      tick();
      drive(1'b1, 4'h0, 16'h0200, 16'h0002, 8'h0, 3'd2);
      tick();
      n_cmp++; if ({bus.InReady, bus.OutValid, bus.RdAddrOut} !== {1'b0, 1'b1, 3'd1}) begin n_err++; $display("FAIL skid_full got rdy=%b v=%b rd=%0d want 0/1/1", bus.InReady, bus.OutValid, bus.RdAddrOut); end
      drive(1'b1, 4'h0, 16'h0300, 16'h0003, 8'h0, 3'd3);
      tick();
      n_cmp++; if ({bus.InReady, bus.A, bus.RdAddrOut} !== {1'b0, 16'h0100, 3'd1}) begin n_err++; $display("FAIL skid_hold got rdy=%b a=%h rd=%0d want 0/0100/1", bus.InReady, bus.A, bus.RdAddrOut); end
      bus.OutReady = 1'b1;
      tick();
      n_cmp++; if ({bus.InReady, bus.A, bus.RdAddrOut} !== {1'b1, 16'h0200, 3'd2}) begin n_err++; $display("FAIL skid_drain got rdy=%b a=%h rd=%0d want 1/0200/2", bus.InReady, bus.A, bus.RdAddrOut); end
      tick();
      drive(1'b0, 4'h0, 16'h0, 16'h0, 8'h0, 3'd0);
      n_cmp++; if ({bus.OutValid, bus.A, bus.RdAddrOut} !== {1'b1, 16'h0300, 3'd3}) begin n_err++; $display("FAIL skid_third got v=%b a=%h rd=%0d want 1/0300/3", bus.OutValid, bus.A, bus.RdAddrOut); end
      tick();
      n_cmp++; if (bus.OutValid !== 1'b0) begin n_err++; $display("FAIL skid_empty got %b want 0", bus.OutValid); end
   endtask

   task automatic test_illegal_sat();
      logic [3:0] opcs [7];
      opcs = '{4'h0, 4'h8, 4'h1, 4'hF, 4'h2, 4'h9, 4'h3};
      for (int i = 0; i < 300; i++) begin
         bus.OutReady = 1'($urandom_range(0, 1));
         drive(1'b1, 4'hF, 16'($urandom), 16'($urandom), 8'($urandom), 3'($urandom));
         tick();
         n_cmp++; if (bus.OutValid !== 1'b0) begin n_err++; $display("FAIL illegal_visible cycle %0d got %b want 0", i, bus.OutValid); end
      end
      n_cmp++; if (bus.IllegalCount !== 8'hFF) begin n_err++; $display("FAIL illegal_saturate got %h want ff", bus.IllegalCount); end
      bus.OutReady = 1'b1;
      for (int i = 0; i < 7; i++) begin
         drive(1'b1, opcs[i], 16'h0, 16'h0, 8'h0, 3'(i));
         tick();
         if (opcs[i] < 4'h8) begin
            n_cmp++; if ({bus.OutValid, bus.RdAddrOut} !== {1'b1, 3'(i)}) begin n_err++; $display("FAIL mixed_order idx %0d got v=%b rd=%0d want 1/%0d", i, bus.OutValid, bus.RdAddrOut, i); end
         end else begin
            n_cmp++; if (bus.OutValid !== 1'b0) begin n_err++; $display("FAIL mixed_drop idx %0d got %b want 0", i, bus.OutValid); end
         end
      end
      drive(1'b0, 4'h0, 16'h0, 16'h0, 8'h0, 3'd0);
      tick();
      n_cmp++; if (bus.IllegalCount !== 8'hFF) begin n_err++; $display("FAIL mixed_count got %h want ff", bus.IllegalCount); end
   endtask

   task automatic test_reset_full();
      bus.OutReady = 1'b0;
      drive(1'b1, 4'h2, 16'hAAAA, 16'h1111, 8'h0, 3'd5);
      tick();
      drive(1'b1, 4'h3, 16'hBBBB, 16'h2222, 8'h0, 3'd6);
      tick();
      drive(1'b0, 4'h0, 16'h0, 16'h0, 8'h0, 3'd0);
      Reset = 1'b1;
      tick();
      n_cmp++; if ({bus.OutValid, bus.InReady, bus.IllegalCount} !== 10'b0) begin n_err++; $display("FAIL rstfull_state got v=%b rdy=%b cnt=%h want 0/0/00", bus.OutValid, bus.InReady, bus.IllegalCount); end
      n_cmp++; if (snap() !== '0) begin n_err++; $display("FAIL rstfull_outputs got %h want 0", snap()); end
      Reset = 1'b0;
      bus.OutReady = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_cmp++; if (bus.OutValid !== 1'b0) begin n_err++; $display("FAIL rstfull_ghost cycle %0d got %b want 0", i, bus.OutValid); end
      end
   endtask

   task automatic test_random();
      logic [ENT_W-1:0] exp_q [$];
      int               cnt_model;
      logic [3:0]       opc;
      logic [15:0]      rs, rt;
      logic [7:0]       imm;
      logic [2:0]       rd;
      logic             acc, con;
      cnt_model = 0;
      for (int i = 0; i < 600; i++) begin
         opc = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
         rs  = 16'($urandom);
         rt  = 16'($urandom);
         imm = 8'($urandom);
         rd  = 3'($urandom);
         drive(1'($urandom_range(0, 3) != 0), opc, rs, rt, imm, rd);
         bus.OutReady = 1'($urandom_range(0, 2) != 0);
         acc = bus.InValid & bus.InReady;
         con = bus.OutValid & bus.OutReady;
         if (con) begin
            n_cmp++;
            if (exp_q.size() == 0) begin n_err++; $display("FAIL rand_spurious cycle %0d got %h want none", i, snap()); end
            else if (snap() !== exp_q[0]) begin n_err++; $display("FAIL rand_data cycle %0d got %h want %h", i, snap(), exp_q[0]); end
            if (exp_q.size() != 0) void'(exp_q.pop_front());
         end
         if (acc) begin
            if (opc < 4'h8) exp_q.push_back(ref_entry(opc, rs, rt, imm, rd));
            else if (cnt_model < 255) cnt_model++;
         end
         tick();
         n_cmp++;
         if ({bus.OutValid, bus.InReady, bus.IllegalCount} !== {exp_q.size() > 0, exp_q.size() < 2, 8'(cnt_model)}) begin
            n_err++;
            $display("FAIL rand_state cycle %0d got v=%b rdy=%b cnt=%h want v=%b rdy=%b cnt=%h", i,
                     bus.OutValid, bus.InReady, bus.IllegalCount, exp_q.size() > 0, exp_q.size() < 2, 8'(cnt_model));
         end
         if (exp_q.size() == 0) begin
            n_cmp++; if (snap() !== '0) begin n_err++; $display("FAIL rand_idle_zero cycle %0d got %h want 0", i, snap()); end
         end
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      Reset = 1'b1;
      bus.OutReady = 1'b0;
      drive(1'b0, 4'h0, 16'h0, 16'h0, 8'h0, 3'd0);
      test_reset();
      test_sub();
      test_imm();
      test_skid();
      test_illegal_sat();
      test_reset_full();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
